// File: rtl/ifetch.sv
// Instruction fetch unit: FETCH/WAIT/HOLD handshake between npc, instruction memory and decode.
// Define IFETCH_ALIGN_CHECK_EN to word-align accepted niaddr values and flag misalignment.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] niaddr,
  output logic [31:0] iaddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic        fetch_err,
  output logic        addr_err
);

  typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ins_q;
  logic        ins_valid_q;
  logic        fetch_err_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_inc;
  logic [31:0] pc_next;
  logic        accept;

  assign cnt_inc = cnt_q + 8'd1;
  assign accept  = (state_q == StHold) && ins_ready;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic addr_err_q;

  assign pc_next = {niaddr[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_err_q <= 1'b0;
    end else if (accept && (niaddr[1:0] != 2'b00)) begin
      addr_err_q <= 1'b1;
    end
  end

  assign addr_err = addr_err_q;
`else
  assign pc_next  = niaddr;
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      ins_q       <= '0;
      ins_valid_q <= 1'b0;
      cnt_q       <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: state_q <= StWait;
        StWait: begin
          // Data wins over a timeout landing in the same cycle.
          if (imem_rvalid) begin
            ins_q       <= imem_rdata;
            ins_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StHold;
          end else if (cnt_inc == TimeoutCnt) begin
            fetch_err_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StFetch;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StHold: begin
          if (ins_ready) begin
            pc_q        <= pc_next;
            ins_valid_q <= 1'b0;
            state_q     <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  assign iaddr     = pc_q;
  assign imem_addr = pc_q;
  assign imem_req  = (state_q == StFetch);
  assign ins       = ins_q;
  assign ins_valid = ins_valid_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: directed fetches push expected addresses and words,
// a negedge monitor pops and compares on each imem_req and on each decode accept.
module tb_ifetch;

  localparam logic [31:0] RstPc = 32'h0000_3000;
`ifdef IFETCH_ALIGN_CHECK_EN
  localparam logic [31:0] AlignPc  = 32'h0000_3010;
  localparam logic [31:0] AlignErr = 32'd1;
`else
  localparam logic [31:0] AlignPc  = 32'h0000_3012;
  localparam logic [31:0] AlignErr = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] niaddr;
  logic [31:0] iaddr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic        fetch_err;
  logic        addr_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_ins_q[$];

  ifetch #(.RESET_PC(RstPc), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .niaddr     (niaddr),
    .iaddr      (iaddr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .fetch_err  (fetch_err),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every request and every accepted instruction must match the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req) begin
        if (exp_addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL req_unexpected: got imem_addr=%h expected no request", imem_addr);
        end else begin
          check("req_addr", imem_addr, exp_addr_q.pop_front());
        end
      end
      if (ins_valid && ins_ready) begin
        if (exp_ins_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ins_unexpected: got ins=%h expected no accept", ins);
        end else begin
          check("ins_word", ins, exp_ins_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    ins_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_iaddr", iaddr, RstPc);
    check("rst_ins", ins, 32'h0);
    check("rst_ins_valid", 32'(ins_valid), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    @(posedge clk); #1;
    exp_addr_q.push_back(RstPc);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(output int t);
    int n = 0;
    @(negedge clk);
    while (!imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      total++;
      bad++;
      $display("FAIL req_wait: got no imem_req expected one within 40 cycles");
    end
    t = cyc;
  endtask

  // One full transaction; stray rvalid is driven during any stall to prove it is ignored.
  task automatic fetch(input logic [31:0] data, input int stall, input logic [31:0] nia,
                       input logic [31:0] next_exp, output int t);
    logic [31:0] pc0;
    wait_req(t);
    pc0 = iaddr;
    @(posedge clk); #1;
    imem_rvalid = 1'b1;
    imem_rdata = data;
    exp_ins_q.push_back(data);
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    imem_rdata = 32'hdead_beef;
    for (int i = 0; i < stall; i++) begin
      imem_rvalid = 1'b1;
      @(negedge clk);
      check("hold_ins", ins, data);
      check("hold_valid", 32'(ins_valid), 32'd1);
      check("hold_no_req", 32'(imem_req), 32'd0);
      check("hold_iaddr", iaddr, pc0);
      @(posedge clk); #1;
    end
    imem_rvalid = 1'b0;
    ins_ready = 1'b1;
    niaddr = nia;
    exp_addr_q.push_back(next_exp);
    @(posedge clk); #1;
    ins_ready = 1'b0;
    niaddr = 32'h0;
    check("accept_valid_drop", 32'(ins_valid), 32'd0);
    check("accept_iaddr", iaddr, next_exp);
  endtask

  initial begin
    int t0, t1, t2, td;
    niaddr = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    ins_ready = 1'b0;
    do_reset();

    // Back-to-back fetches at full rate.
    fetch(32'h0000_0013, 0, 32'h0000_3004, 32'h0000_3004, t0);
    fetch(32'h0010_0093, 0, 32'h0000_3008, 32'h0000_3008, t1);
    fetch(32'h0020_0113, 0, 32'h0000_300c, 32'h0000_300c, t2);
    check("req_gap_1", 32'(t1 - t0), 32'd3);
    check("req_gap_2", 32'(t2 - t1), 32'd3);

    // Decode stall of 5 cycles.
    fetch(32'h2408_0005, 5, 32'h0000_3010, 32'h0000_3010, td);

    // Misaligned next address.
    fetch(32'h0000_0001, 0, 32'h0000_3012, AlignPc, td);
    check("align_addr_err", 32'(addr_err), AlignErr);

    // Memory never answers: timeout after 15 WAIT cycles, re-issue at the same PC.
    wait_req(td);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("to_wait15_no_req", 32'(imem_req), 32'd0);
    check("to_wait15_no_err", 32'(fetch_err), 32'd0);
    exp_addr_q.push_back(AlignPc);
    @(posedge clk); #1;
    check("to_fetch_err", 32'(fetch_err), 32'd1);
    check("to_reissue_req", 32'(imem_req), 32'd1);
    check("to_same_pc", iaddr, AlignPc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("to_err_sticky", 32'(fetch_err), 32'd1);

    // rvalid exactly on the timeout cycle: data wins.
    do_reset();
    wait_req(td);
    repeat (15) @(posedge clk);
    #1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h00a0_0513;
    exp_ins_q.push_back(32'h00a0_0513);
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    check("edge_ins_valid", 32'(ins_valid), 32'd1);
    check("edge_ins", ins, 32'h00a0_0513);
    check("edge_no_fetch_err", 32'(fetch_err), 32'd0);
    check("edge_no_req", 32'(imem_req), 32'd0);
    ins_ready = 1'b1;
    niaddr = 32'h0000_3004;
    exp_addr_q.push_back(32'h0000_3004);
    @(posedge clk); #1;
    ins_ready = 1'b0;

    // Reset during WAIT, late rvalid and early ins_ready afterwards must be ignored.
    wait_req(td);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_addr_q.push_back(RstPc);
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hbad0_0001;
    ins_ready = 1'b1;
    niaddr = 32'h0000_5000;
    @(negedge clk);
    check("rstw_ins_valid", 32'(ins_valid), 32'd0);
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    check("rstw_late_ignored_valid", 32'(ins_valid), 32'd0);
    check("rstw_late_ignored_ins", ins, 32'h0);
    check("rstw_pc_kept", iaddr, RstPc);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0050_0593;
    exp_ins_q.push_back(32'h0050_0593);
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    check("rstw_ready_ignored_in_wait", iaddr, RstPc);
    check("rstw_hold_valid", 32'(ins_valid), 32'd1);
    exp_addr_q.push_back(32'h0000_5000);
    @(posedge clk); #1;
    ins_ready = 1'b0;
    check("rstw_next_pc", iaddr, 32'h0000_5000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("end_addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    check("end_ins_q_empty", 32'(exp_ins_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL be the PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 15 (range 1..255), SHALL be the number of WAIT cycles without imem_rvalid before a timeout.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 niaddr  in  32  SHALL be the next instruction address from npc.
REQ-006 iaddr  out  32  SHALL be the current PC, driven to npc.
REQ-007 imem_req  out  1  SHALL be the fetch request strobe.
REQ-008 imem_addr  out  32  SHALL be the fetch address, valid while imem_req=1.
REQ-009 imem_rvalid  in  1  SHALL be the memory response valid.
REQ-010 imem_rdata  in  32  SHALL be the memory response word.
REQ-011 ins  out  32  SHALL be the held instruction word for decode.
REQ-012 ins_valid  out  1  SHALL indicate that ins is valid.
REQ-013 ins_ready  in  1  SHALL be the decode accept, i.e. the stall release.
REQ-014 fetch_err  out  1  SHALL be the sticky timeout flag.
REQ-015 addr_err  out  1  SHALL be the sticky misaligned-niaddr flag (see Configuration).

Function
REQ-016 The block SHALL implement a three-state FSM: FETCH, WAIT, HOLD.
REQ-017 FETCH: imem_req=1 and imem_addr=pc for exactly one cycle, then WAIT unconditionally.
REQ-018 WAIT: each cycle without imem_rvalid, wait counter +1; on imem_rvalid, ins<=imem_rdata, ins_valid<=1, counter<=0, next state HOLD.
REQ-019 WAIT timeout: when the counter reaches TIMEOUT with imem_rvalid=0, fetch_err<=1, counter<=0, next state FETCH, pc unchanged (re-issue).
REQ-020 Simultaneous imem_rvalid=1 and timeout in the same cycle: data SHALL win; no fetch_err.
REQ-021 HOLD: ins and ins_valid=1 stable until ins_ready=1; on ins_ready=1, pc<=niaddr, ins_valid<=0, next state FETCH.
REQ-022 ins_ready SHALL be ignored outside HOLD.
REQ-023 imem_rvalid SHALL be ignored outside WAIT; stray responses SHALL not alter ins or state.
REQ-024 iaddr SHALL equal pc at all times, combinationally from the register.
REQ-025 imem_req=0 and imem_addr=pc in WAIT and HOLD.
REQ-026 Minimum throughput: one instruction per 3 cycles (FETCH, WAIT with immediate rvalid, HOLD with ins_ready=1).
REQ-027 The wait counter SHALL be 8 bits; pc SHALL wrap modulo 2^32 with no special handling.
REQ-028 fetch_err and addr_err SHALL be sticky and cleared only by reset.

Reset
REQ-029 When rst_n=0 at a clock edge: pc<=RESET_PC, state<=FETCH, ins<=0, ins_valid<=0, counter<=0, fetch_err<=0, addr_err<=0.
REQ-030 Reset during WAIT or HOLD SHALL abandon the transaction; a late imem_rvalid after reset SHALL be ignored per REQ-023.
REQ-031 The first cycle after reset release SHALL issue imem_req=1 with imem_addr=RESET_PC.

Configuration
REQ-032 Macro IFETCH_ALIGN_CHECK_EN defined: at HOLD accept, if niaddr[1:0]!=0, addr_err<=1 and pc<={niaddr[31:2],2'b00}.
REQ-033 Macro IFETCH_ALIGN_CHECK_EN undefined: pc<=niaddr unmodified, and addr_err SHALL be tied to 0.

Verification
REQ-034 Reset, then rvalid=1 one cycle after req, ins_ready=1, niaddr=pc+4: imem_addr sequence 0x3000, 0x3004, 0x3008, with one req every 3 cycles.
REQ-035 ins_ready held 0 for 5 cycles in HOLD with imem_rdata=0x2408_0005: ins stays 0x2408_0005, ins_valid=1, no new imem_req, iaddr constant.
REQ-036 imem_rvalid never asserted, TIMEOUT=15: fetch_err=1 after 15 WAIT cycles, imem_req re-issued at the same address, state cycles without advancing pc.
REQ-037 imem_rvalid asserted on the exact timeout cycle: ins captured, fetch_err remains 0.
REQ-038 rst_n=0 during WAIT, then rvalid=1 after release: ignored; next imem_addr=0x3000 and ins_valid=0.
REQ-039 IFETCH_ALIGN_CHECK_EN defined, niaddr=0x0000_3012 at accept: pc=0x0000_3010, addr_err=1; undefined: pc=0x0000_3012, addr_err=0.
